// File: rtl/axis_bus_pkg.sv
// Shared constants, select codes and arbiter state type for the AXI-Stream
// channel arbiter and the tready demux that decodes its bus_sel code.
package axis_bus_pkg;

  localparam int unsigned N_CH  = 6;
  localparam int unsigned IDX_W = 3;

  localparam logic [7:0] CHOOSE_FIFO_BASE = 8'd128;
  localparam logic [7:0] NON_FIFO_CHOOSE  = 8'd0;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/axis_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting channel after 'last',
// wrapping from N_CH-1 back to 0.
module rr_pick
  import axis_bus_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = IDX_W'((32'(last) + 32'(k)) % N_CH);
      if (req[w_idx]) begin
        gnt_idx = w_idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_bus_arbiter.sv
// Packet-locked round-robin arbiter of six AXI-Stream sources onto one output,
// with bus_sel code for the tready demux. ARB_TIMEOUT_EN adds an idle timeout.
module axis_bus_arbiter
  import axis_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_BASE = 32'(CHOOSE_FIFO_BASE)
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          s_tvalid,
  input  logic [N_CH-1:0]          s_tlast,
  input  logic [N_CH*DATA_W-1:0]   s_tdata,
  output logic [N_CH-1:0]          s_tready,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  output logic [DATA_W-1:0]        m_tdata,
  input  logic                     m_tready,
  output logic [7:0]               bus_sel
`ifdef ARB_TIMEOUT_EN
  , output logic                   timeout_flag
`endif
);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [7:0]       r_bus_sel, w_bus_sel_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_g_valid;
  logic [DATA_W-1:0] w_lane [N_CH];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic             r_timeout_flag, w_timeout_nxt;
`endif

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    assign w_lane[gi] = s_tdata[gi*DATA_W +: DATA_W];
  end

  rr_pick u_pick (
    .req     (s_tvalid),
    .last    (r_last_grant),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_g_valid = s_tvalid[r_grant];

  // Next-state and zero-latency forward mux; outputs forced low during reset.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_bus_sel_nxt    = r_bus_sel;
    s_tready         = '0;
    m_tvalid         = 1'b0;
    m_tlast          = 1'b0;
    m_tdata          = '0;
`ifdef ARB_TIMEOUT_EN
    w_idle_cnt_nxt   = r_idle_cnt;
    w_timeout_nxt    = r_timeout_flag;
`endif
    case (r_state)
      IDLE: begin
        w_bus_sel_nxt = NON_FIFO_CHOOSE;
        if (w_pick_any) begin
          w_grant_nxt   = w_pick_idx;
          w_bus_sel_nxt = 8'(SEL_BASE + 32'(w_pick_idx));
          w_state_nxt   = LOCK;
`ifdef ARB_TIMEOUT_EN
          w_idle_cnt_nxt = '0;
`endif
        end
      end
      LOCK: begin
        if (!rst) begin
          m_tvalid          = w_g_valid;
          m_tlast           = s_tlast[r_grant];
          m_tdata           = w_lane[r_grant];
          s_tready[r_grant] = m_tready;
        end
        if (w_g_valid && m_tready && s_tlast[r_grant]) begin
          w_last_grant_nxt = r_grant;
          w_bus_sel_nxt    = NON_FIFO_CHOOSE;
          w_state_nxt      = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        if (w_g_valid) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_last_grant_nxt = r_grant;
          w_bus_sel_nxt    = NON_FIFO_CHOOSE;
          w_state_nxt      = IDLE;
          w_timeout_nxt    = 1'b1;
          w_idle_cnt_nxt   = '0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // last_grant resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_CH - 1);
      r_bus_sel    <= NON_FIFO_CHOOSE;
`ifdef ARB_TIMEOUT_EN
      r_idle_cnt     <= '0;
      r_timeout_flag <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_bus_sel    <= w_bus_sel_nxt;
`ifdef ARB_TIMEOUT_EN
      r_idle_cnt     <= w_idle_cnt_nxt;
      r_timeout_flag <= w_timeout_nxt;
`endif
    end
  end

  assign bus_sel = r_bus_sel;
`ifdef ARB_TIMEOUT_EN
  assign timeout_flag = r_timeout_flag;
`endif

endmodule

// File: tb/tb_axis_bus_arbiter.sv
// Scoreboard bench for axis_bus_arbiter: packet-level round-robin reference
// model feeds an expected-beat queue that a free-running monitor consumes.
module tb_axis_bus_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned NCH  = 6;
  localparam int unsigned SELB = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [2:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    src_valid;
  logic [NCH-1:0]    sup = '0;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tlast;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tready;
  logic              m_tvalid;
  logic              m_tlast;
  logic [DW-1:0]     m_tdata;
  logic              m_tready;
  logic [7:0]        bus_sel;
`ifdef ARB_TIMEOUT_EN
  logic              timeout_flag;
`endif

  beat_t src_q [NCH][$];
  beat_t mdl_q [NCH][$];
  exp_t  exp_q [$];

  int n_pass = 0;
  int n_total = 0;
  int n_beats = 0;
  int ready_pct = 100;
  int model_last = 5;

  assign s_tvalid = src_valid & ~sup;

  always #5 clk = ~clk;

  axis_bus_arbiter #(
    .DATA_W (DW)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT (10)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .m_tready (m_tready),
    .bus_sel  (bus_sel)
`ifdef ARB_TIMEOUT_EN
    , .timeout_flag (timeout_flag)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
  endtask

  function automatic bit src_busy();
    for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Source FIFO model: add a packet both to the driven queue and to the model.
  task automatic add_pkt(input int ch, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      src_q[ch].push_back(b);
      mdl_q[ch].push_back(b);
    end
  endtask

  // Reference: serve whole packets, next pending channel after the last served one.
  task automatic schedule();
    int    pick;
    int    c;
    beat_t b;
    exp_t  e;
    while (1) begin
      pick = -1;
      for (int k = 1; k <= NCH; k++) begin
        c = (model_last + k) % NCH;
        if (pick < 0 && mdl_q[c].size() != 0) pick = c;
      end
      if (pick < 0) break;
      do begin
        b = mdl_q[pick].pop_front();
        e.ch   = 3'(pick);
        e.data = b.data;
        e.last = b.last;
        exp_q.push_back(e);
      end while (!b.last);
      model_last = pick;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || src_busy()) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_exp_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sel(input logic [7:0] code);
    int cyc = 0;
    while (bus_sel !== code && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_bus_sel", 64'(bus_sel), 64'(code));
  endtask

  task automatic clear_all();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      mdl_q[c].delete();
    end
    model_last = 5;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 clear_all();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Input driver: pops accepted beats, presents queue heads, randomises m_tready.
  initial begin : drv
    logic [NCH-1:0] hs;
    src_valid = '0;
    s_tlast   = '0;
    s_tdata   = '0;
    m_tready  = 1'b0;
    forever begin
      @(posedge clk);
      hs = s_tready & s_tvalid;
      #1;
      for (int c = 0; c < NCH; c++)
        if (hs[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
      m_tready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
      for (int c = 0; c < NCH; c++) begin
        if (src_q[c].size() != 0) begin
          src_valid[c]        = 1'b1;
          s_tlast[c]          = src_q[c][0].last;
          s_tdata[c*DW +: DW] = src_q[c][0].data;
        end else begin
          src_valid[c]        = 1'b0;
          s_tlast[c]          = 1'b0;
          s_tdata[c*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor: compare every accepted beat and the cycle following each tlast.
  initial begin : mon
    exp_t           e;
    logic           after_last;
    logic [NCH-1:0] want_rdy;
    after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (after_last) begin
        chk("release_bus_sel", 64'(bus_sel), 64'(0));
        chk("bubble_tvalid", 64'(m_tvalid), 64'(0));
      end
      after_last = 1'b0;
      want_rdy   = '0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got data 0x%0h with no beat expected at %0t", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          n_beats++;
          want_rdy = NCH'(1) << e.ch;
          chk("m_tdata", 64'(m_tdata), 64'(e.data));
          chk("m_tlast", 64'(m_tlast), 64'(e.last));
          chk("bus_sel_beat", 64'(bus_sel), 64'(SELB + 32'(e.ch)));
          after_last = m_tlast;
        end
      end
      chk("s_tready", 64'(s_tready), 64'(want_rdy));
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int start;
    int cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bus_sel", 64'(bus_sel), 64'(0));
    chk("reset_m_tvalid", 64'(m_tvalid), 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single channel, 3-beat packet.
    add_pkt(0, 3);
    schedule();
    wait_sel(8'd128);
    drain();

    // All channels with 1-beat packets from reset: 0..5 then 0 again.
    do_reset();
    for (int c = 0; c < NCH; c++) add_pkt(c, 1);
    add_pkt(0, 1);
    schedule();
    drain();

    // Channel 2 multi-beat packet under a stalling consumer.
    ready_pct = 50;
    add_pkt(2, 4);
    schedule();
    drain();

    // Channel 1 arrives while channel 4 holds the lock.
    ready_pct = 100;
    add_pkt(4, 4);
    schedule();
    wait_sel(8'd132);
    add_pkt(1, 1);
    schedule();
    drain();

    // Reset after the second of five beats truncates the packet.
    start = n_beats;
    add_pkt(0, 5);
    schedule();
    cyc = 0;
    while (n_beats < start + 2 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    chk("trunc_beats_before_rst", 64'(n_beats - start), 64'(2));
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("trunc_bus_sel", 64'(bus_sel), 64'(0));
    chk("trunc_m_tvalid", 64'(m_tvalid), 64'(0));
    @(posedge clk);
    #2 clear_all();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    add_pkt(3, 2);
    add_pkt(0, 2);
    schedule();
    drain();

    // Randomised batches with random consumer backpressure.
    ready_pct = 70;
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int j = 0; j < n; j++) add_pkt(c, int'($urandom_range(1, 4)));
      end
      schedule();
      drain();
    end
    ready_pct = 100;

`ifdef ARB_TIMEOUT_EN
    // Lock channel 3, then starve it until the idle limit forces release.
    do_reset();
    ready_pct = 0;
    @(posedge clk);
    @(negedge clk);
    src_q[3].push_back('{data: 32'h3333_0001, last: 1'b0});
    src_q[3].push_back('{data: 32'h3333_0002, last: 1'b1});
    wait_sel(8'd131);
    sup[3] = 1'b1;
    repeat (9) @(negedge clk);
    chk("timeout_still_locked", 64'(bus_sel), 64'(131));
    chk("timeout_flag_before", 64'(timeout_flag), 64'(0));
    @(negedge clk);
    chk("timeout_bus_sel", 64'(bus_sel), 64'(0));
    chk("timeout_flag_set", 64'(timeout_flag), 64'(1));
    src_q[3].delete();
    @(posedge clk);
    #2 sup = '0;
    ready_pct = 100;
    model_last = 3;
    @(negedge clk);
    add_pkt(4, 1);
    schedule();
    wait_sel(8'd132);
    drain();
    chk("timeout_flag_sticky", 64'(timeout_flag), 64'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
